// File: rtl/reg_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reg_access_ctrl_pkg
// Shared core package for the register access controller.
// Holds the default register data / index widths and the read-FSM state
// encoding used by reg_access_ctrl.
// ---------------------------------------------------------------------------
package reg_access_ctrl_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    // Read FSM: wait for a decode request, read the register file (possibly
    // stalling on a writeback hazard), then hold operands until execute takes them.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_READ = 2'd1,
        RD_HOLD = 2'd2
    } rd_state_e;

endpackage

// File: rtl/reg_access_ctrl_wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Single-entry write stage. A writeback offered on wb_valid is registered and
// presented to the register file for exactly one cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wb_valid, wb_rd, wb_data incoming writeback request
//   reg_write_en             write strobe (set for any registered writeback)
//   rd_valid                 write qualifier (low for writes to x0)
//   rd, rd_data              write index and data
// ---------------------------------------------------------------------------
module wb_stage
    import reg_access_ctrl_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              reg_write_en,
    output logic              rd_valid,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_data
);

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;

    // Index and data hold their last value when no writeback arrives.
    always_comb begin
        valid_d = wb_valid;
        rd_d    = rd_q;
        data_d  = data_q;
        if (wb_valid) begin
            rd_d   = wb_rd;
            data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // x0 writes still pulse the strobe but carry no architectural effect.
    assign reg_write_en = valid_q;
    assign rd_valid     = valid_q && (rd_q != '0);
    assign rd           = rd_q;
    assign rd_data      = data_q;

endmodule

// File: rtl/reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// reg_access_ctrl
// Register access controller: accepts source-operand requests from decode,
// reads the register file, stalls on a RAW hazard against the write stage,
// and holds captured operands for execute. Writebacks flow through wb_stage
// concurrently with the read path.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   dec_*                             decode request (valid/ready, indices, used)
//   reg_read_en, rs1/rs2_valid, rs1/2 register-file read strobe and indices
//   rs1_data, rs2_data                combinational register-file read data
//   op_valid/op_ready, op_a, op_b     operand handshake toward execute
//   wb_valid/wb_ready, wb_rd, wb_data writeback request
//   reg_write_en, rd_valid, rd, rd_data register-file write port
// ---------------------------------------------------------------------------
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_rs1_used,
    input  logic              dec_rs2_used,
    output logic              reg_read_en,
    output logic              rs1_valid,
    output logic              rs2_valid,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              reg_write_en,
    output logic              rd_valid,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_data
);

    rd_state_e         state_q, state_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic              rs1_used_q, rs1_used_d;
    logic              rs2_used_q, rs2_used_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic              hazard;

    wb_stage #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_wb_stage (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .reg_write_en (reg_write_en),
        .rd_valid     (rd_valid),
        .rd           (rd),
        .rd_data      (rd_data)
    );

    // The write stage commits at the end of this cycle, so a matching source
    // would read stale data now; waiting one cycle picks up the new value.
    // rd_valid already excludes x0 writes.
    always_comb begin
        hazard = rd_valid &&
                 ((rs1_used_q && (rs1_q != '0) && (rd == rs1_q)) ||
                  (rs2_used_q && (rs2_q != '0) && (rd == rs2_q)));
    end

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_used_d = rs1_used_q;
        rs2_used_d = rs2_used_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        case (state_q)
            RD_IDLE: begin
                if (dec_valid) begin
                    rs1_d      = dec_rs1;
                    rs2_d      = dec_rs2;
                    rs1_used_d = dec_rs1_used;
                    rs2_used_d = dec_rs2_used;
                    state_d    = RD_READ;
                end
            end
            RD_READ: begin
                // Unused sources and x0 always yield zero regardless of read data.
                if (!hazard) begin
                    op_a_d  = (rs1_used_q && (rs1_q != '0)) ? rs1_data : '0;
                    op_b_d  = (rs2_used_q && (rs2_q != '0)) ? rs2_data : '0;
                    state_d = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (op_ready) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RD_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_used_q <= 1'b0;
            rs2_used_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_used_q <= rs1_used_d;
            rs2_used_q <= rs2_used_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
        end
    end

    // Ready signals are gated by rst so they read low while reset is held.
    assign dec_ready   = rst && (state_q == RD_IDLE);
    assign wb_ready    = rst;
    assign reg_read_en = (state_q == RD_READ) && !hazard;
    assign rs1_valid   = reg_read_en && rs1_used_q;
    assign rs2_valid   = reg_read_en && rs2_used_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign op_valid    = (state_q == RD_HOLD);
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_access_ctrl
// Directed bench for reg_access_ctrl. A small register-file model answers
// reads and commits writes. Expected operand pairs are queued when a request
// is issued; a monitor pops them whenever execute accepts operands.
// ---------------------------------------------------------------------------
module tb_reg_access_ctrl;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic        reg_read_en;
    logic        rs1_valid;
    logic        rs2_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        reg_write_en;
    logic        rd_valid;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q [$];

    // x0 holds junk in the model so the controller's zero forcing is observable.
    logic [31:0] regs [32] = '{0: 32'hDEAD_BEEF, 5: 32'h11, 6: 32'h22, 7: 32'hFF,
                               default: 32'h0};

    reg_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .reg_read_en  (reg_read_en),
        .rs1_valid    (rs1_valid),
        .rs2_valid    (rs2_valid),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .reg_write_en (reg_write_en),
        .rd_valid     (rd_valid),
        .rd           (rd),
        .rd_data      (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register-file model: combinational read, commit at end of write cycle.
    assign rs1_data = regs[rs1];
    assign rs2_data = regs[rs2];

    always @(posedge clk) begin
        if (reg_write_en && rd_valid) regs[rd] <= rd_data;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of decode and/or writeback request, returning one
    // time step after the edge that samples it.
    task automatic applyStimulus(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic u1, input logic u2, input logic wv,
                                 input logic [4:0] wrd, input logic [31:0] wdat);
        dec_valid    = dv;
        dec_rs1      = r1;
        dec_rs2      = r2;
        dec_rs1_used = u1;
        dec_rs2_used = u2;
        wb_valid     = wv;
        wb_rd        = wrd;
        wb_data      = wdat;
        @(negedge clk);
        if (dv) checkOutput("dec_ready_idle", dec_ready, 1);
        nextCycle;
        dec_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    // Scoreboard monitor: every execute acceptance must match a queued pair.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && op_valid && op_ready) begin
                checkOutput("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) checkOutput("operands", {op_a, op_b}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
        dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
        op_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_ctrl", {dec_ready, wb_ready, op_valid, reg_read_en,
                                 rs1_valid, rs2_valid, reg_write_en, rd_valid}, 0);
        checkOutput("rst_ops", {op_a, op_b}, 0);
        checkOutput("rst_idx", {rs1, rs2, rd, rd_data}, 0);
        nextCycle;
        rst = 1'b1;

        // Basic read, minimum latency; accepted at first edge after release
        exp_q.push_back({32'h11, 32'h22});
        applyStimulus(1, 5'd5, 5'd6, 1, 1, 0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("read_strobes", {reg_read_en, rs1_valid, rs2_valid, dec_ready, op_valid}, 5'b11100);
        checkOutput("read_idx", {rs1, rs2}, {5'd5, 5'd6});
        nextCycle;
        @(negedge clk);
        checkOutput("op_valid_n2", {op_valid, dec_ready}, 2'b10);
        nextCycle;
        @(negedge clk);
        checkOutput("back_idle", {op_valid, dec_ready}, 2'b01);
        nextCycle;

        // x0 and unused sources read as zero
        exp_q.push_back({32'h0, 32'h0});
        applyStimulus(1, 5'd0, 5'd7, 1, 0, 0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("x0_read_quals", {reg_read_en, rs1_valid, rs2_valid}, 3'b110);
        nextCycle;
        nextCycle;

        // Writeback hazard on rs1: one stall cycle, then the new value
        exp_q.push_back({32'hABCD, 32'h22});
        applyStimulus(1, 5'd5, 5'd6, 1, 1, 1, 5'd5, 32'hABCD);
        @(negedge clk);
        checkOutput("stall_read", {reg_read_en, rs1_valid, rs2_valid, op_valid}, 0);
        checkOutput("stall_write", {reg_write_en, rd_valid, rd}, {1'b1, 1'b1, 5'd5});
        nextCycle;
        @(negedge clk);
        checkOutput("after_stall", {reg_read_en, rs1_valid, op_valid}, 3'b110);
        nextCycle;
        @(negedge clk);
        checkOutput("stall_op_valid", op_valid, 1);
        nextCycle;
        nextCycle;

        // Write to x0: strobe without qualifier
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 1, 5'd0, 32'h1234);
        @(negedge clk);
        checkOutput("x0_write", {reg_write_en, rd_valid, rd, rd_data}, {1'b1, 1'b0, 5'd0, 32'h1234});
        nextCycle;
        @(negedge clk);
        checkOutput("x0_write_done", reg_write_en, 0);
        checkOutput("x0_unwritten", regs[0], 32'hDEAD_BEEF);
        nextCycle;
        exp_q.push_back({32'h0, 32'h0});
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0);
        nextCycle;
        nextCycle;

        // Back-to-back writebacks, each one cycle in the write stage
        applyStimulus(0, 5'd0, 5'd0, 0, 0, 1, 5'd9, 32'h99);
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hAA;
        @(negedge clk);
        checkOutput("b2b_first", {reg_write_en, rd, rd_data}, {1'b1, 5'd9, 32'h99});
        nextCycle;
        wb_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_second", {reg_write_en, rd, rd_data}, {1'b1, 5'd10, 32'hAA});
        nextCycle;
        @(negedge clk);
        checkOutput("b2b_drained", reg_write_en, 0);
        nextCycle;
        exp_q.push_back({32'h99, 32'hAA});
        applyStimulus(1, 5'd9, 5'd10, 1, 1, 0, 5'd0, 32'h0);
        nextCycle;
        nextCycle;

        // Execute back-pressure: operands stable for 4 cycles
        op_ready = 1'b0;
        exp_q.push_back({32'h22, 32'hABCD});
        applyStimulus(1, 5'd6, 5'd5, 1, 1, 0, 5'd0, 32'h0);
        nextCycle;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("hold_stable", {op_valid, dec_ready, op_a, op_b},
                        {1'b1, 1'b0, 32'h22, 32'hABCD});
            nextCycle;
        end
        op_ready = 1'b1;
        nextCycle;
        @(negedge clk);
        checkOutput("hold_released", {op_valid, dec_ready}, 2'b01);
        nextCycle;

        // Reset during HOLD discards the request
        op_ready = 1'b0;
        applyStimulus(1, 5'd5, 5'd6, 1, 1, 0, 5'd0, 32'h0);
        nextCycle;
        @(negedge clk);
        checkOutput("pre_reset_hold", op_valid, 1);
        nextCycle;
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset", {op_valid, dec_ready, wb_ready, op_a, op_b},
                    {1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        op_ready = 1'b1;
        nextCycle;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_idle", {op_valid, dec_ready, wb_ready}, 3'b011);
            nextCycle;
        end

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter REG_AW, default 5, register index width (32 registers).
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  Reset is asynchronous and active-low.
REQ-005 dec_valid  in  1  decoded instruction offers source operands.
REQ-006 dec_ready  out  1  controller accepts the source request.
REQ-007 dec_rs1, dec_rs2  in  REG_AW each  source indices.
REQ-008 dec_rs1_used, dec_rs2_used  in  1 each  source actually needed.
REQ-009 reg_read_en  out  1  register-file read strobe.
REQ-010 rs1_valid, rs2_valid  out  1 each  per-port read qualifiers.
REQ-011 rs1, rs2  out  REG_AW each  register-file read indices.
REQ-012 rs1_data, rs2_data  in  XLEN each  register-file read data, combinational on index.
REQ-013 op_valid  out  1  operands valid toward execute.
REQ-014 op_ready  in  1  execute accepts operands.
REQ-015 op_a, op_b  out  XLEN each  captured operands.
REQ-016 wb_valid  in  1  writeback request.
REQ-017 wb_ready  out  1  writeback accepted; constant 1 outside reset.
REQ-018 wb_rd  in  REG_AW; wb_data  in  XLEN  writeback target and value.
REQ-019 reg_write_en, rd_valid  out  1 each  register-file write strobe and qualifier.
REQ-020 rd  out  REG_AW; rd_data  out  XLEN  register-file write index and data.

Function
REQ-021 Read FSM states: IDLE, READ, HOLD.
REQ-022 IDLE: dec_ready=1; on dec_valid, latch indices and used flags, go to READ.
REQ-023 READ: reg_read_en=1, rs1_valid/rs2_valid = latched used flags, rs1/rs2 = latched indices; on no hazard, capture operands and go to HOLD.
REQ-024 Hazard: write stage valid and its rd nonzero and equal to a used nonzero source; in that case deassert reg_read_en and both read qualifiers, remain in READ one more cycle.
REQ-025 Operand capture: op_a = 0 if rs1 unused or index 0, else rs1_data; op_b likewise.
REQ-026 HOLD: op_valid=1; op_a/op_b stable until op_ready; on op_valid&op_ready go to IDLE.
REQ-027 dec_ready=0 in READ and HOLD; minimum latency dec accept at edge N -> op_valid high in cycle N+2.
REQ-028 Write stage: on wb_valid at edge N, register wb_rd/wb_data; in cycle N+1 drive reg_write_en=1, rd=wb_rd, rd_data=wb_data, rd_valid=(wb_rd!=0); register file commits at end of cycle N+1.
REQ-029 Write to index 0: reg_write_en=1, rd_valid=0, no architectural effect.
REQ-030 Back-to-back writebacks accepted every cycle; each occupies the write stage exactly one cycle.
REQ-031 Write and read paths operate concurrently; a hazard stall never exceeds the number of consecutive matching writebacks.
REQ-032 Outside READ, reg_read_en, rs1_valid, rs2_valid = 0; rs1/rs2 hold last value.

Reset
REQ-033 rst low asynchronously forces FSM to IDLE and write stage empty.
REQ-034 During reset: dec_ready, wb_ready, op_valid, reg_read_en, rs1_valid, rs2_valid, reg_write_en, rd_valid = 0; op_a, op_b, rd_data = 0; rs1, rs2, rd = 0.
REQ-035 Reset asserted mid-READ or mid-HOLD discards the request; no op_valid after release until a new dec handshake.
REQ-036 After rst release, first possible dec accept and wb accept at the first posedge.

Structure
REQ-037 XLEN, REG_AW defaults and the read-FSM state enum reside in the shared core package.
REQ-038 Write stage is a sub-module wb_stage (register plus x0 qualifier); read FSM stays in the top.

Verification
REQ-039 Reset then dec rs1=5, rs2=6 used, regfile x5=0x11, x6=0x22 -> op_valid at N+2, op_a=0x11, op_b=0x22.
REQ-040 dec rs1=0 used, rs2 unused, rs2 index 7 holding 0xFF -> op_a=0, op_b=0, rs2_valid=0 during READ.
REQ-041 wb rd=5 data=0xABCD in the same cycle READ of rs1=5 -> one stall cycle with reg_read_en=0, then op_a=0xABCD.
REQ-042 wb rd=0 data=0x1234 -> reg_write_en=1, rd_valid=0 one cycle; later read of x0 gives 0.
REQ-043 op_ready held low 4 cycles -> op_valid, op_a, op_b stable 4 cycles, dec_ready=0 throughout, IDLE after accept.
REQ-044 rst asserted in HOLD -> op_valid=0 immediately; after release op_valid stays 0 until new dec_valid.
